serial_readout_sequencer: RTL

SERIAL_READOUT_SEQUENCER -- requirements
Module: serial_readout_sequencer

---
 rtl/serial_readout_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/serial_readout_sequencer.sv
// Serial readout sequencer: walks the enabled channels of a latched mask,
// emitting per channel a header (start bit + channel index, MSB first)
// followed by BITS_PER_CH bits shifted out of that channel's serial source.
// Outside a frame the SPI register-readback stream is forwarded instead.
module serial_readout_sequencer #(
    parameter int NUM_CH      = 8,
    parameter int BITS_PER_CH = 50
) (
    input  logic                        sclk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NUM_CH-1:0]           ch_mask,
    input  logic [NUM_CH-1:0]           raw_serial_out,
    input  logic                        wr_serial_out,
    output logic [NUM_CH-1:0]           load_cnt_ser,
    output logic                        serial_out,
    output logic                        busy,
    output logic                        frame_done,
    output logic [$clog2(NUM_CH)-1:0]   cur_ch
);

    localparam int CH_W    = $clog2(NUM_CH);
    // Counter must hold the last index of the longer of the header and data phases.
    localparam int CNT_MAX = (BITS_PER_CH > 1 + CH_W) ? BITS_PER_CH : 1 + CH_W;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(CH_W);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(BITS_PER_CH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic [CH_W-1:0]   ch_n;
    logic [NUM_CH-1:0] mask_q;
    logic [NUM_CH-1:0] mask_n;

    logic [CH_W-1:0]   first_idx;
    logic [CH_W-1:0]   next_idx;
    logic              next_found;
    logic              hdr_bit;
    logic              ser_src;

    // Lowest enabled channel of the incoming mask, and next enabled channel above cur_ch
    always_comb begin
        first_idx  = '0;
        next_idx   = '0;
        next_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                first_idx = CH_W'(i);
            end
            if (mask_q[i] && (i > int'(cur_ch))) begin
                next_idx   = CH_W'(i);
                next_found = 1'b1;
            end
        end
    end

    // Header bit for the current counter position: start bit, then cur_ch MSB first
    always_comb begin
        hdr_bit = 1'b1;
        for (int k = 0; k < CH_W; k++) begin
            if (int'(cnt) == CH_W - k) begin
                hdr_bit = cur_ch[k];
            end
        end
    end

    // Next-state and next-counter decisions for the sequencer
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ch_n    = cur_ch;
        mask_n  = mask_q;
        case (state)
            IDLE: begin
                if (start) begin
                    cnt_n = '0;
                    if (|ch_mask) begin
                        mask_n  = ch_mask;
                        ch_n    = first_idx;
                        state_n = HDR;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            HDR: begin
                if (cnt == HDR_LAST) begin
                    cnt_n   = '0;
                    state_n = DATA;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt == DATA_LAST) begin
                    cnt_n = '0;
                    if (next_found) begin
                        ch_n    = next_idx;
                        state_n = HDR;
                    end else begin
                        state_n = DONE;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                cnt_n   = '0;
                mask_n  = '0;
                state_n = IDLE;
            end
        endcase
    end

    // Sequencer state plus registered control outputs decoded from the next state
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            cur_ch       <= '0;
            mask_q       <= '0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            load_cnt_ser <= '0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            cur_ch       <= ch_n;
            mask_q       <= mask_n;
            busy         <= (state_n != IDLE);
            frame_done   <= (state_n == DONE);
            load_cnt_ser <= (state_n == DATA) ? (NUM_CH'(1) << ch_n) : '0;
        end
    end

    // Source of the serial stream for the current state
    always_comb begin
        case (state)
            IDLE:    ser_src = wr_serial_out;
            HDR:     ser_src = hdr_bit;
            DATA:    ser_src = raw_serial_out[cur_ch];
            default: ser_src = 1'b0;
        endcase
    end

    // Serial output register: one sclk of latency from the selected source
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            serial_out <= 1'b0;
        end else begin
            serial_out <= ser_src;
        end
    end

endmodule
